// File: rtl/muxn_arb_pkg.sv
// Shared types and helpers for the muxn_arb N-way handshaked selector.
package muxn_arb_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } arb_mode_t;

  function automatic int next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/muxn_arb_rr_pick.sv
// Rotating priority encoder: first requester at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    // Lowest requester overall covers the wrapped case.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = SEL_W'(i);
      end
    end
    // Lowest requester at or above ptr takes precedence.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (SEL_W'(i) >= ptr)) begin
        idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/muxn_arb.sv
// Registered N-way valid/ready selector, directed or round-robin.
// Optional MUXN_ARB_LOCK_EN adds a lock input that holds rr priority.
module muxn_arb
  import muxn_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  arb_mode_t          mode,
  input  logic [SEL_W-1:0]   sel,
`ifdef MUXN_ARB_LOCK_EN
  input  logic               lock,
`endif
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  input  logic               out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [SEL_W-1:0] grant;
  logic             grant_en;
  logic             can_load;
  logic             dir_ok;
  logic             adv;
  logic [WIDTH-1:0] grant_data;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req (in_valid),
    .ptr (rr_ptr),
    .any (rr_any),
    .idx (rr_idx)
  );

  assign can_load = !out_valid || out_ready;

  // Out-of-range sel matches no channel and so never grants.
  always_comb begin
    dir_ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i)) dir_ok = in_valid[i];
    end
  end

  always_comb begin
    grant    = '0;
    grant_en = 1'b0;
    unique case (mode)
      MODE_DIRECT: begin
        grant    = sel;
        grant_en = can_load && dir_ok;
      end
      MODE_RR: begin
        grant    = rr_idx;
        grant_en = can_load && rr_any;
      end
    endcase
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = !rst && grant_en;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MUXN_ARB_LOCK_EN
  assign adv = grant_en && (mode == MODE_RR) && !lock;
`else
  assign adv = grant_en && (mode == MODE_RR);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (grant_en) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_src   <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (adv) begin
        rr_ptr <= SEL_W'(next_idx(int'(grant), N));
      end
    end
  end

endmodule

// File: tb/tb_muxn_arb.sv
// Scoreboard bench for muxn_arb: an 8-channel and a 5-channel instance.
module tb_muxn_arb;
  import muxn_arb_pkg::*;

  typedef struct packed {
    logic [2:0]  src;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_mode_t    mode8;
  logic [2:0]   sel8;
  logic [7:0]   iv8;
  logic [127:0] id8;
  logic [7:0]   ir8;
  logic         ov8;
  logic [15:0]  od8;
  logic [2:0]   os8;
  logic         ordy8;

  arb_mode_t    mode5;
  logic [2:0]   sel5;
  logic [4:0]   iv5;
  logic [79:0]  id5;
  logic [4:0]   ir5;
  logic         ov5;
  logic [15:0]  od5;
  logic [2:0]   os5;
  logic         ordy5;

`ifdef MUXN_ARB_LOCK_EN
  logic lock8;
  logic lock5;
`endif

  exp_t q8[$];
  exp_t q5[$];
  exp_t e8;
  exp_t e5;
  int   n_cmp = 0;
  int   n_err = 0;

  muxn_arb #(.WIDTH(16), .N(8)) u8 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode8),
    .sel       (sel8),
`ifdef MUXN_ARB_LOCK_EN
    .lock      (lock8),
`endif
    .in_valid  (iv8),
    .in_data   (id8),
    .in_ready  (ir8),
    .out_valid (ov8),
    .out_data  (od8),
    .out_src   (os8),
    .out_ready (ordy8)
  );

  muxn_arb #(.WIDTH(16), .N(5)) u5 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode5),
    .sel       (sel5),
`ifdef MUXN_ARB_LOCK_EN
    .lock      (lock5),
`endif
    .in_valid  (iv5),
    .in_data   (id5),
    .in_ready  (ir5),
    .out_valid (ov5),
    .out_data  (od5),
    .out_src   (os5),
    .out_ready (ordy5)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input int src, input logic [15:0] data);
    q8.push_back('{src: 3'(src), data: data});
  endtask

  task automatic push5(input int src, input logic [15:0] data);
    q5.push_back('{src: 3'(src), data: data});
  endtask

  always @(negedge clk) begin
    if (!rst && ov8 && ordy8) begin
      if (q8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL u8 unexpected word: src %0d data %0h, expected none",
                 os8, od8);
      end else begin
        e8 = q8.pop_front();
        chk("u8 out_src", 32'(os8), 32'(e8.src));
        chk("u8 out_data", 32'(od8), 32'(e8.data));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov5 && ordy5) begin
      if (q5.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL u5 unexpected word: src %0d data %0h, expected none",
                 os5, od5);
      end else begin
        e5 = q5.pop_front();
        chk("u5 out_src", 32'(os5), 32'(e5.src));
        chk("u5 out_data", 32'(od5), 32'(e5.data));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    mode8 = MODE_RR;
    sel8  = '0;
    iv8   = '0;
    ordy8 = 1'b0;
    mode5 = MODE_RR;
    sel5  = '0;
    iv5   = '0;
    ordy5 = 1'b0;
`ifdef MUXN_ARB_LOCK_EN
    lock8 = 1'b0;
    lock5 = 1'b0;
`endif
    for (int i = 0; i < 8; i++) id8[i*16 +: 16] = 16'h1000 + 16'(i);
    for (int i = 0; i < 5; i++) id5[i*16 +: 16] = 16'h2000 + 16'(i);

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(ov8), 0);
    chk("reset out_data", 32'(od8), 0);
    chk("reset out_src", 32'(os8), 0);
    chk("reset in_ready", 32'(ir8), 0);
    rst = 1'b0;

    // Directed, sel=5, everything valid.
    mode8 = MODE_DIRECT;
    sel8  = 3'd5;
    iv8   = 8'hFF;
    ordy8 = 1'b1;
    #1;
    chk("dir sel5 in_ready", 32'(ir8), 32'h20);
    push8(5, 16'h1005);
    step();

    // Directed at an idle channel: no grant, output drains.
    sel8 = 3'd3;
    iv8  = 8'hF7;
    #1;
    chk("dir idle in_ready", 32'(ir8), 0);
    step();
    chk("dir idle drained", 32'(ov8), 0);

    // Round-robin over all eight channels, one word per cycle.
    mode8 = MODE_RR;
    iv8   = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("rr in_ready", 32'(ir8), 32'(1) << (k % 8));
      push8(k % 8, 16'h1000 + 16'(k % 8));
      step();
    end

    // Back-pressure holds word from channel 1.
    ordy8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp in_ready", 32'(ir8), 0);
      chk("bp out_valid", 32'(ov8), 1);
      chk("bp out_src", 32'(os8), 1);
      chk("bp out_data", 32'(od8), 32'h1001);
      step();
    end
    ordy8 = 1'b1;
    #1;
    chk("bp release in_ready", 32'(ir8), 32'h04);
    push8(2, 16'h1002);
    step();
    iv8 = '0;
    step();
    chk("bp drained", 32'(ov8), 0);

    // Reset while a word is held.
    iv8   = 8'hFF;
    ordy8 = 1'b0;
    #1;
    chk("pre-reset in_ready", 32'(ir8), 32'h08);
    step();
    chk("pre-reset out_valid", 32'(ov8), 1);
    rst = 1'b1;
    #1;
    chk("async reset out_valid", 32'(ov8), 0);
    chk("async reset out_data", 32'(od8), 0);
    chk("async reset out_src", 32'(os8), 0);
    chk("async reset in_ready", 32'(ir8), 0);
    step();
    rst   = 1'b0;
    ordy8 = 1'b1;
`ifdef MUXN_ARB_LOCK_EN
    for (int k = 0; k < 5; k++) begin
      lock8 = (k < 3);
      #1;
      chk("lock in_ready", 32'(ir8), (k == 4) ? 32'h02 : 32'h01);
      push8((k == 4) ? 1 : 0, (k == 4) ? 16'h1001 : 16'h1000);
      step();
    end
    lock8 = 1'b0;
`else
    #1;
    chk("post-reset in_ready", 32'(ir8), 32'h01);
    push8(0, 16'h1000);
    step();
`endif
    iv8 = '0;
    step();
    chk("post-reset drained", 32'(ov8), 0);

    // Five channels, only 1 and 4 requesting: pointer wraps 4->0.
    mode5 = MODE_RR;
    iv5   = 5'b10010;
    ordy5 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("n5 rr in_ready", 32'(ir5), (k % 2 == 1) ? 32'h10 : 32'h02);
      push5((k % 2 == 1) ? 4 : 1, (k % 2 == 1) ? 16'h2004 : 16'h2001);
      step();
    end

    // sel beyond N never grants.
    mode5 = MODE_DIRECT;
    sel5  = 3'd6;
    iv5   = 5'h1F;
    #1;
    chk("n5 sel>=N in_ready", 32'(ir5), 0);
    step();
    chk("n5 sel>=N drained", 32'(ov5), 0);

    // Directed grant must not move the rr pointer (still 0).
    sel5 = 3'd2;
    #1;
    chk("n5 dir in_ready", 32'(ir5), 32'h04);
    push5(2, 16'h2002);
    step();
    mode5 = MODE_RR;
    #1;
    chk("n5 rr after dir in_ready", 32'(ir5), 32'h01);
    push5(0, 16'h2000);
    step();
    iv5 = '0;
    step();
    step();

    chk("u8 queue empty", 32'(q8.size()), 0);
    chk("u5 queue empty", 32'(q5.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
